// File: rtl/shift_word_receiver_if.sv
// Bus bundle between a serial link front end and the word receiver.
// master: the side driving the serial strobes and the downstream ready.
// slave : the receiver itself.
interface shift_word_receiver_if #(
  parameter int WIDTH = 4
);
  logic             shiftIn;
  logic             left;
  logic             right;
  logic             abort;
  logic             dataReady;
  logic [WIDTH-1:0] data;
  logic             dataValid;
  logic             busy;
  logic             frameError;
  logic             overrun;

  modport master (
    output shiftIn, left, right, abort, dataReady,
    input  data, dataValid, busy, frameError, overrun
  );

  modport slave (
    input  shiftIn, left, right, abort, dataReady,
    output data, dataValid, busy, frameError, overrun
  );
endinterface

// File: rtl/shift_word_receiver.sv
// Serial-to-parallel word receiver. Rebuilds WIDTH-bit words from a serial
// stream strobed MSB-first (left) or LSB-first (right) and hands each word
// downstream through a registered valid/ready output.
module shift_word_receiver #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  shift_word_receiver_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;        // 1'b0 = left (MSB-first), 1'b1 = right
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic             accept_s;
  logic             restart_s;
  logic             complete_s;
  logic [WIDTH-1:0] shifted_s;
  logic [CW-1:0]    cnt_base_s;
  logic [CW-1:0]    cnt_inc_s;

  // Both strobes together carry no bit; abort swallows any strobe in its cycle.
  assign accept_s   = (bus.left ^ bus.right) & ~bus.abort;
  // A direction change mid-word drops the partial word and starts over.
  assign restart_s  = accept_s & (state_q == RECV) & (bus.right != dir_q);
  assign shifted_s  = bus.left ? {sr_q[WIDTH-2:0], bus.shiftIn}
                               : {bus.shiftIn, sr_q[WIDTH-1:1]};
  assign cnt_base_s = ((state_q == RECV) && !restart_s) ? cnt_q : {CW{1'b0}};
  assign cnt_inc_s  = cnt_base_s + {{(CW-1){1'b0}}, 1'b1};
  assign complete_s = accept_s & (cnt_inc_s == CW'(WIDTH));

  // State register for the FSM, the assembly datapath and all outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      dir_q   <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic: FSM transition plus shift register, counter and direction.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE, RECV: begin
        if (bus.abort) begin
          state_d = IDLE;
          sr_d    = {WIDTH{1'b0}};
          cnt_d   = {CW{1'b0}};
        end else if (accept_s) begin
          dir_d = bus.right;
          sr_d  = shifted_s;
          if (complete_s) begin
            state_d = IDLE;
            cnt_d   = {CW{1'b0}};
          end else begin
            state_d = RECV;
            cnt_d   = cnt_inc_s;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        sr_d    = {WIDTH{1'b0}};
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // Output logic: word hand-off, handshake, overrun and frame-error flags.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (complete_s) begin
      data_d  = shifted_s;
      valid_d = 1'b1;
      ovr_d   = ovr_q | (valid_q & ~bus.dataReady);
    end else if (valid_q && bus.dataReady) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    ferr_d = restart_s;
    busy_d = (state_d == RECV);
  end

  assign bus.data       = data_q;
  assign bus.dataValid  = valid_q;
  assign bus.busy       = busy_q;
  assign bus.frameError = ferr_q;
  assign bus.overrun    = ovr_q;
endmodule

// File: doc/shift_word_receiver.md
# shift_word_receiver

Serial-to-parallel receiver that pairs with the team's 4-bit bidirectional shift transmitters. It samples `shiftIn` while the shift strobes `left` or `right` are active and rebuilds the original word in either bit order. Each completed word is presented on a registered parallel output with a valid/ready handshake. It sits at the far end of the serial link, feeding downstream logic that consumes whole words.

## Interface
- `WIDTH`, default 4: word width in bits, legal values ≥ 2.
- `clk`  input  1  rising-edge clock for all state.
- `reset`  input  1  one clock; reset is synchronous and active-high.
- `shiftIn`  input  1  serial data bit, sampled on an accepted strobe.
- `left`  input  1  strobe: bit present, MSB-first order (transmitter shifting left).
- `right`  input  1  strobe: bit present, LSB-first order (transmitter shifting right).
- `abort`  input  1  discards the partially assembled word.
- `dataReady`  input  1  downstream accepts `data` when `dataValid` is high.
- `data`  output  WIDTH  last completed word, registered.
- `dataValid`  output  1  `data` holds an unconsumed word.
- `busy`  output  1  a partial word is in progress (bit count ≠ 0).
- `frameError`  output  1  one-cycle pulse: partial word dropped because of a direction change.
- `overrun`  output  1  sticky: a completed word overwrote an unconsumed one.

## Operation
- Internal state: assembly register `sr[WIDTH-1:0]`, bit counter `cnt` (0..WIDTH-1), latched direction `dir`, and FSM {IDLE (cnt=0), RECV (cnt>0)}.
- Accepted bit: exactly one of `left`/`right` high, `abort` low, `reset` low. When both strobes are high, the cycle is ignored: no sample, no count, no flag.
- IDLE with an accepted bit:
  - latch `dir` from the strobe;
  - for left: `sr <= {sr[WIDTH-2:0], shiftIn}`; for right: `sr <= {shiftIn, sr[WIDTH-1:1]}`;
  - `cnt <= 1`; go to RECV.
- RECV with an accepted bit in the same direction: shift as above and increment `cnt`.
- RECV with an accepted bit in the opposite direction:
  - drop the partial word and pulse `frameError` for one cycle;
  - treat the bit as the first bit of a new word (latch new `dir`, `cnt <= 1`).
- Completion: when the accepted bit is the WIDTH-th bit, load `data` with the shifted value, set `dataValid`, clear `cnt`, and return to IDLE.
  - MSB-first: the first bit lands in `data[WIDTH-1]`.
  - LSB-first: the first bit lands in `data[0]`.
- Handshake: `dataValid` stays high and `data` stays stable until a cycle with `dataValid && dataReady`. That cycle clears `dataValid`, unless a word also completes in that same cycle.
- Completion while `dataValid` is high and `dataReady` is low: the new word overwrites `data`, `dataValid` stays 1, and `overrun` is set. `overrun` clears only on `reset`.
- Completion in the same cycle as consumption: the new word loads, `dataValid` stays 1, and no overrun is flagged.
- `abort`: `cnt <= 0`, `sr <= 0`, go to IDLE. `data`, `dataValid` and `overrun` are untouched. `abort` beats a simultaneous strobe, and that bit is lost.

## Timing
- Reset values: `data=0`, `dataValid=0`, `busy=0`, `frameError=0`, `overrun=0`, `sr=0`, `cnt=0`, state IDLE.
- `reset` overrides every input in the same edge, including mid-word and during a pending `dataValid`.
- All outputs are registered.
- `data`/`dataValid` update at the edge that samples the WIDTH-th bit, so they are visible in the following cycle.
- Minimum word time is WIDTH cycles; back-to-back words need no gap.
- `busy` is high from the edge after the first bit until the completing edge.
- `frameError` is high for exactly the one cycle after the offending edge.
- The transmitter registers `shiftOut` one cycle after its strobe. Integration delays the strobes by one register stage so that `shiftIn` and the strobe coincide at this block.

## Test plan
- After reset, drive `left` with `shiftIn` = 1,0,1,1 on consecutive cycles and hold `dataReady` low -> `data=4'b1011` and `dataValid=1` after the 4th edge; `busy` is high for cycles 2–4.
- Drive `right` with `shiftIn` = 1,1,0,0 -> `data=4'b0011`. Then pulse `dataReady` for one cycle -> `dataValid=0` on the next cycle.
- Send 2 bits with `left`, then a cycle with `left` and `right` both high, then 2 more `left` bits (1,0 / x / 0,1) -> the both-high cycle is ignored and `data=4'b1001`.
- Send 2 bits with `left`, then 4 bits with `right` (1,0,1,0) -> `frameError` pulses once on the first `right` bit, and `data=4'b0101` after the 4th `right` bit.
- Complete word A=4'h6 and leave it unconsumed, then complete word B=4'h9 -> `data=4'h9`, `dataValid=1`, `overrun=1`. Repeat with `dataReady` high on B's completing edge -> no overrun.
- Assert `reset` after 3 of 4 bits and `abort` after 2 of 4 bits in separate runs -> after reset, all outputs are 0; after abort, `busy=0` and earlier `data`/`dataValid` are retained; the next 4 bits form a clean word.
